input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent button channels (1..16).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel (2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to change level (10 ms at 100 MHz game_clk).
REQ-004 Parameter REPEAT_DELAY, default 40000000: held cycles from press pulse to first repeat pulse.
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent repeat pulses.
REQ-006 Parameter ACTIVE_LOW, default NUM_CH'b1..1: per-channel inversion of the raw pad value (KEY pads are active low).
REQ-007 Parameter REPEAT_MASK, default 0: per-channel auto-repeat enable; left/right movement channels set it.
REQ-008 clk  input  1  game clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 btn_raw  input  NUM_CH  asynchronous pad values.
REQ-011 enable  input  1  when low, press/release/repeat pulses are forced to 0; level tracking continues.
REQ-012 btn_level  output  NUM_CH  debounced, active-high pressed state.
REQ-013 btn_press  output  NUM_CH  one-cycle pulse on 0->1 of btn_level.
REQ-014 btn_release  output  NUM_CH  one-cycle pulse on 1->0 of btn_level.
REQ-015 btn_repeat  output  NUM_CH  one-cycle auto-repeat pulse.
REQ-016 any_press  output  1  OR of btn_press.

Function
REQ-017 Each channel shall invert btn_raw when its ACTIVE_LOW bit is set, then pass it through SYNC_STAGES flops; channels fully independent.
REQ-018 Debounce counter, width $clog2(DEBOUNCE_CYCLES+1), increments each cycle the synchronised value differs from btn_level and clears to 0 on any cycle it agrees.
REQ-019 When the counter would reach DEBOUNCE_CYCLES, btn_level shall toggle and the counter clear, in the same cycle.
REQ-020 Input-to-level latency shall be exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles for a clean edge; glitches shorter than DEBOUNCE_CYCLES cycles shall never change btn_level.
REQ-021 btn_press/btn_release shall assert in the same cycle btn_level changes, registered (no combinational path from btn_raw).
REQ-022 Per-channel FSM states: IDLE (level 0), HELD (level 1, counting REPEAT_DELAY), REPEATING (level 1, counting REPEAT_PERIOD).
REQ-023 IDLE->HELD on level rise, repeat counter cleared; HELD->REPEATING when counter reaches REPEAT_DELAY, btn_repeat pulses, counter cleared; in REPEATING, counter reaching REPEAT_PERIOD pulses btn_repeat and clears.
REQ-024 Any state -> IDLE on level fall; no repeat pulse on the release cycle, even if the counter expires that cycle.
REQ-025 Channels with REPEAT_MASK bit 0 shall stay in HELD and never pulse btn_repeat.
REQ-026 Repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); saturation is impossible because it clears on expiry.
REQ-027 enable low shall gate pulses only; FSM and counters keep running, so re-asserting enable mid-hold resumes repeats on the existing schedule with no retroactive press.
REQ-028 Simultaneous events on different channels in one cycle shall all be reported.

Reset
REQ-029 While reset is high at a clk edge: synchroniser flops load the inactive (post-inversion 0) value, btn_level=0, all counters 0, all FSMs IDLE, all pulse outputs and any_press 0.
REQ-030 Reset asserted mid-hold or mid-debounce shall discard progress; a button still held after reset shall produce a fresh btn_press after SYNC_STAGES+DEBOUNCE_CYCLES cycles.

Structure
REQ-031 Package input_cond_pkg shall hold the channel state enum (IDLE, HELD, REPEATING) and default timing constants.
REQ-032 Sub-module input_cond_channel (one channel: synchroniser, debounce, FSM) shall be generated NUM_CH times; top level adds only inversion, enable gating and any_press.

Verification (NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=4'b1111, REPEAT_MASK=4'b0011)
REQ-033 btn_raw[2] 1->0 held -> btn_level[2]=1 and btn_press[2] pulse exactly 6 cycles later; no btn_repeat[2] ever.
REQ-034 btn_raw[0] low 3 cycles then high -> btn_level[0] stays 0, no pulses.
REQ-035 btn_raw[0] held low 30 cycles -> press at T, repeats at T+10, T+13, T+16, ...; release pulse 6 cycles after raw returns high, no repeat that cycle.
REQ-036 Channels 0 and 3 pressed same cycle -> btn_press=4'b1001 in one cycle, any_press=1 once.
REQ-037 enable=0 during press of ch1 -> btn_level[1]=1, no press pulse; enable=1 at T+12 -> next repeat at T+13.
REQ-038 reset pulsed at T+5 while ch0 held -> all outputs 0 next cycle; fresh press 6 cycles after reset deasserts.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared types and default timing for the button input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } ch_state_e;

  localparam int unsigned DEF_NUM_CH          = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 40000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One button channel: synchroniser, debounce counter and press/hold/repeat FSM.
// Pulse outputs are next-cycle values; the parent registers them.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic press_c,
  output logic release_c,
  output logic repeat_c
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt, db_cnt_d, db_inc;
  logic [RPT_W-1:0]       rpt_cnt, rpt_cnt_d, rpt_inc;
  logic                   level_d;
  logic                   synced;
  ch_state_e              state, state_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // State register: synchroniser, debounce, level, FSM and repeat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      db_cnt  <= '0;
      level   <= 1'b0;
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad};
      db_cnt  <= db_cnt_d;
      level   <= level_d;
      state   <= state_d;
      rpt_cnt <= rpt_cnt_d;
    end
  end

  // Next-state: debounce decides the new level, the FSM reacts in the same cycle.
  always_comb begin
    level_d   = level;
    db_cnt_d  = '0;
    db_inc    = db_cnt + DB_W'(1);
    state_d   = state;
    rpt_cnt_d = rpt_cnt;
    rpt_inc   = rpt_cnt + RPT_W'(1);
    press_c   = 1'b0;
    release_c = 1'b0;
    repeat_c  = 1'b0;

    if (synced != level) begin
      if (db_inc == DB_W'(DEBOUNCE_CYCLES)) level_d = ~level;
      else                                  db_cnt_d = db_inc;
    end

    case (state)
      IDLE: begin
        if (level_d) begin
          press_c   = 1'b1;
          state_d   = HELD;
          rpt_cnt_d = '0;
        end
      end
      HELD: begin
        if (!level_d) begin
          release_c = 1'b1;
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rpt_inc == RPT_W'(REPEAT_DELAY)) begin
            repeat_c  = 1'b1;
            state_d   = REPEATING;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_inc;
          end
        end
      end
      REPEATING: begin
        if (!level_d) begin
          release_c = 1'b1;
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_inc == RPT_W'(REPEAT_PERIOD)) begin
          repeat_c  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: pad inversion, per-channel debounce/repeat,
// enable gating of pulses and an any-press summary.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned       NUM_CH          = DEF_NUM_CH,
  parameter int unsigned       SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned       REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned       REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW      = '1,
  parameter logic [NUM_CH-1:0] REPEAT_MASK     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic              enable,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat,
  output logic              any_press
);

  logic [NUM_CH-1:0] press_c, release_c, repeat_c;
  logic [NUM_CH-1:0] gate;

  assign gate = {NUM_CH{enable}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .pad      (btn_raw[i] ^ ACTIVE_LOW[i]),
      .level    (btn_level[i]),
      .press_c  (press_c[i]),
      .release_c(release_c[i]),
      .repeat_c (repeat_c[i])
    );
  end

  // Pulses are registered alongside the level change; enable masks them only.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      any_press   <= 1'b0;
    end else begin
      btn_press   <= press_c & gate;
      btn_release <= release_c & gate;
      btn_repeat  <= repeat_c & gate;
      any_press   <= |(press_c & gate);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with short debounce/repeat timing.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic       any_press;

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .ACTIVE_LOW(4'b1111), .REPEAT_MASK(4'b0011)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .enable(enable),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  rpt;
    logic        any;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int unsigned cy, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] t, input logic a);
    ev_t e;
    e.cyc = cy; e.press = p; e.rel = r; e.rpt = t; e.any = a;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: any pulse on the outputs must match the next expected event.
  always @(negedge clk) begin
    if ((|btn_press) || (|btn_release) || (|btn_repeat) || any_press) begin
      ev_t got, want;
      got.cyc = cyc; got.press = btn_press; got.rel = btn_release;
      got.rpt = btn_repeat; got.any = any_press;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: got cyc=%0d p=%b r=%b t=%b a=%b, expected no pulse",
                 got.cyc, got.press, got.rel, got.rpt, got.any);
      end else begin
        want = sb.pop_front();
        if (got === want) passes++;
        else $display("FAIL event: got cyc=%0d p=%b r=%b t=%b a=%b, expected cyc=%0d p=%b r=%b t=%b a=%b",
                      got.cyc, got.press, got.rel, got.rpt, got.any,
                      want.cyc, want.press, want.rel, want.rpt, want.any);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    reset = 1'b1; enable = 1'b1; btn_raw = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_level",   32'(btn_level),   32'h0);
    check("reset_press",   32'(btn_press),   32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    check("reset_repeat",  32'(btn_repeat),  32'h0);
    check("reset_any",     32'(any_press),   32'h0);
    reset = 1'b0;

    // Three-cycle glitch on ch0 never reaches the level
    @(negedge clk); c = cyc;
    btn_raw[0] = 1'b0;
    wait_until(c + 3); btn_raw[0] = 1'b1;
    wait_until(c + 12);
    check("glitch_level", 32'(btn_level), 32'h0);

    // ch2 press: 6-cycle latency, no repeats (mask bit clear)
    c = cyc;
    btn_raw[2] = 1'b0;
    expect_ev(c + 6, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_until(c + 5); check("ch2_level_early", 32'(btn_level), 32'h0);
    wait_until(c + 6); check("ch2_level_set",   32'(btn_level), 32'h4);
    wait_until(c + 40);
    btn_raw[2] = 1'b1;
    expect_ev(c + 46, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    wait_until(c + 46); check("ch2_level_clear", 32'(btn_level), 32'h0);
    wait_until(c + 50);

    // ch0 auto-repeat; release lands on a would-be repeat cycle
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    for (int k = 0; k < 7; k++)
      expect_ev(c + 16 + 3 * k, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    wait_until(c + 31);
    check("ch0_level_held", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b1;
    expect_ev(c + 37, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_until(c + 42);

    // ch0 and ch3 pressed together
    c = cyc;
    btn_raw = 4'b0110;
    expect_ev(c + 6, 4'b1001, 4'b0000, 4'b0000, 1'b1);
    wait_until(c + 8); check("dual_level", 32'(btn_level), 32'h9);
    btn_raw = 4'hF;
    expect_ev(c + 14, 4'b0000, 4'b1001, 4'b0000, 1'b0);
    wait_until(c + 18);

    // enable low during ch1 press; re-enabled at T+12 picks up repeat at T+13
    c = cyc;
    enable = 1'b0; btn_raw[1] = 1'b0;
    wait_until(c + 6); check("en_level", 32'(btn_level), 32'h2);
    wait_until(c + 18);
    enable = 1'b1; btn_raw[1] = 1'b1;
    expect_ev(c + 19, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    expect_ev(c + 22, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    expect_ev(c + 24, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    wait_until(c + 28);

    // reset mid-hold discards progress; fresh press after reset
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_ev(c + 6, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    wait_until(c + 10); reset = 1'b1;
    wait_until(c + 11);
    check("midreset_level",  32'(btn_level),  32'h0);
    check("midreset_pulses", 32'({btn_press, btn_release, btn_repeat, any_press}), 32'h0);
    reset = 1'b0;
    expect_ev(c + 17, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    wait_until(c + 16); check("postreset_level_early", 32'(btn_level), 32'h0);
    wait_until(c + 18);
    btn_raw[0] = 1'b1;
    expect_ev(c + 24, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    wait_until(c + 30);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
